// File: rtl/bp_fe_fetch_tracker_if.sv
// bp_fe_fetch_tracker_if: fetch, memory-response, replay and FE-queue signals of the fetch tracker
interface bp_fe_fetch_tracker_if #(
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32
);
  logic                       fetch_v_i;
  logic [vaddr_width_p-1:0]   fetch_pc_i;
  logic                       fetch_ready_o;
  logic                       mem_resp_v_i;
  logic [instr_width_p+3:0]   mem_resp_i;
  logic                       flush_i;
  logic                       poison_o;
  logic                       replay_v_o;
  logic [vaddr_width_p-1:0]   replay_pc_o;
  logic                       out_v_o;
  logic [vaddr_width_p-1:0]   out_pc_o;
  logic [instr_width_p-1:0]   out_instr_o;
  logic [1:0]                 out_exc_o;
  logic                       out_yumi_i;
  modport slave (
    input  fetch_v_i, fetch_pc_i, mem_resp_v_i, mem_resp_i, flush_i, out_yumi_i,
    output fetch_ready_o, poison_o, replay_v_o, replay_pc_o, out_v_o, out_pc_o, out_instr_o, out_exc_o
  );
  modport master (
    output fetch_v_i, fetch_pc_i, mem_resp_v_i, mem_resp_i, flush_i, out_yumi_i,
    input  fetch_ready_o, poison_o, replay_v_o, replay_pc_o, out_v_o, out_pc_o, out_instr_o, out_exc_o
  );
endinterface

// File: rtl/bp_fe_fetch_tracker.sv
// bp_fe_fetch_tracker: aligns fetch PCs with the 2-cycle memory-stage response and buffers FE queue entries
module bp_fe_fetch_tracker #(
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int fifo_els_p    = 4
) (
  input logic                  clk_i,
  input logic                  reset_n_i,
  bp_fe_fetch_tracker_if.slave io
);
  localparam int ptr_w = $clog2(fifo_els_p);
  localparam int cnt_w = $clog2(fifo_els_p + 1);
  localparam int crd_w = ptr_w + 2;
  localparam logic [ptr_w-1:0] last_ptr = ptr_w'(fifo_els_p - 1);
  logic                     s1_v, s2_v, replay_v;
  logic [vaddr_width_p-1:0] s1_pc, s2_pc, replay_pc;
  logic [ptr_w-1:0]         rptr, wptr;
  logic [cnt_w-1:0]         cnt;
  logic [crd_w-1:0]         credit_use;
  logic [vaddr_width_p-1:0] pc_mem    [fifo_els_p];
  logic [instr_width_p-1:0] instr_mem [fifo_els_p];
  logic [1:0]               exc_mem   [fifo_els_p];
  logic                     acc, pf, any_miss, resp, miss, enq, deq;
  function automatic logic [ptr_w-1:0] inc(input logic [ptr_w-1:0] p);
    return p == last_ptr ? '0 : p + 1'b1;
  endfunction
  assign acc      = io.mem_resp_i[instr_width_p+3];
  assign pf       = io.mem_resp_i[instr_width_p+2];
  assign any_miss = |io.mem_resp_i[instr_width_p+1:instr_width_p];
  assign resp     = s2_v & io.mem_resp_v_i & ~io.flush_i;
  // faults take priority over misses: a faulting fetch is reported, never replayed
  assign miss     = resp & ~acc & ~pf & any_miss;
  assign enq      = resp & ~miss;
  assign deq      = io.out_yumi_i & (cnt != '0);
  // buffered entries plus fetches still in the pipeline must fit in the buffer
  assign credit_use       = crd_w'(cnt) + crd_w'(s1_v) + crd_w'(s2_v);
  assign io.fetch_ready_o = credit_use < crd_w'(fifo_els_p);
  assign io.poison_o      = io.flush_i | miss;
  assign io.replay_v_o    = replay_v;
  assign io.replay_pc_o   = replay_pc;
  assign io.out_v_o       = cnt != '0;
  assign io.out_pc_o      = io.out_v_o ? pc_mem[rptr] : '0;
  assign io.out_instr_o   = io.out_v_o ? instr_mem[rptr] : '0;
  assign io.out_exc_o     = io.out_v_o ? exc_mem[rptr] : '0;
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_v      <= 1'b0;
      s1_pc     <= '0;
      s2_v      <= 1'b0;
      s2_pc     <= '0;
      replay_v  <= 1'b0;
      replay_pc <= '0;
      wptr      <= '0;
      rptr      <= '0;
      cnt       <= '0;
    end else begin
      s1_v      <= io.fetch_v_i & ~io.flush_i;
      s1_pc     <= io.fetch_pc_i;
      s2_v      <= s1_v & ~io.poison_o;
      s2_pc     <= s1_pc;
      replay_v  <= miss;
      replay_pc <= miss ? s2_pc : replay_pc;
      wptr      <= io.flush_i ? '0 : enq ? inc(wptr) : wptr;
      rptr      <= io.flush_i ? '0 : deq ? inc(rptr) : rptr;
      cnt       <= io.flush_i ? '0 : cnt + cnt_w'(enq) - cnt_w'(deq);
    end
  end
  always_ff @(posedge clk_i) begin
    if (enq) begin
      pc_mem[wptr]    <= s2_pc;
      instr_mem[wptr] <= (acc | pf) ? '0 : io.mem_resp_i[instr_width_p-1:0];
      exc_mem[wptr]   <= acc ? 2'b10 : pf ? 2'b01 : 2'b00;
    end
  end
  a_resp_align: assert property (@(posedge clk_i) disable iff (!reset_n_i) io.mem_resp_v_i == s2_v);
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!reset_n_i) enq |-> (cnt != cnt_w'(fifo_els_p)) || deq);
  a_yumi_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i) io.out_yumi_i |-> io.out_v_o);
endmodule

// File: tb/tb_bp_fe_fetch_tracker.sv
// tb_bp_fe_fetch_tracker: randomized PC gen / memory stage / FE queue against a queue-based reference model
module tb_bp_fe_fetch_tracker;
  localparam int va_w = 39;
  localparam int in_w = 32;
  localparam int n    = 4;
  typedef struct {
    logic [va_w-1:0] pc;
    int              due;
  } fetch_t;
  typedef struct {
    logic [va_w-1:0] pc;
    logic [in_w-1:0] instr;
    logic [1:0]      exc;
  } ent_t;
  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  always #5 clk_i = ~clk_i;
  bp_fe_fetch_tracker_if #(.vaddr_width_p(va_w), .instr_width_p(in_w)) io ();
  bp_fe_fetch_tracker #(.vaddr_width_p(va_w), .instr_width_p(in_w), .fifo_els_p(n)) dut (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .io(io)
  );
  fetch_t          pend[$];
  ent_t            fq[$];
  logic            rv;
  logic [va_w-1:0] rpc;
  int              cyc;
  int              total = 0;
  int              bad = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic drive_idle();
    io.fetch_v_i    = 1'b0;
    io.fetch_pc_i   = '0;
    io.mem_resp_v_i = 1'b0;
    io.mem_resp_i   = '0;
    io.flush_i      = 1'b0;
    io.out_yumi_i   = 1'b0;
  endtask
  task automatic chk_reset_state();
    chk("rst_ready", io.fetch_ready_o, 1);
    chk("rst_out_v", io.out_v_o, 0);
    chk("rst_replay_v", io.replay_v_o, 0);
    chk("rst_poison", io.poison_o, 0);
    chk("rst_replay_pc", io.replay_pc_o, 0);
    chk("rst_out_pc", io.out_pc_o, 0);
    chk("rst_out_instr", io.out_instr_o, 0);
    chk("rst_out_exc", io.out_exc_o, 0);
  endtask
  // one clock cycle; entered and left 1 time unit after a rising edge; probabilities in percent
  task automatic step(input int p_fetch, input int p_yumi, input int p_flush, input int p_miss, input int p_fault);
    logic            resp, miss, acc, pf, tlb, ic;
    logic [in_w-1:0] data;
    fetch_t          f;
    ent_t            e;
    resp = pend.size() > 0 && pend[0].due == cyc;
    acc  = $urandom_range(99) < p_fault;
    pf   = $urandom_range(99) < p_fault;
    tlb  = $urandom_range(99) < p_miss;
    ic   = $urandom_range(99) < p_miss;
    data = $urandom;
    io.fetch_v_i    = (fq.size() + pend.size()) < n && $urandom_range(99) < p_fetch;
    io.fetch_pc_i   = va_w'({$urandom, $urandom});
    io.mem_resp_v_i = resp;
    io.mem_resp_i   = resp ? {acc, pf, tlb, ic, data} : '0;
    io.flush_i      = $urandom_range(99) < p_flush;
    io.out_yumi_i   = fq.size() > 0 && $urandom_range(99) < p_yumi;
    miss = resp && !io.flush_i && !acc && !pf && (tlb || ic);
    #1;
    chk("ready", io.fetch_ready_o, (fq.size() + pend.size()) < n);
    chk("out_v", io.out_v_o, fq.size() > 0);
    if (fq.size() > 0) begin
      chk("out_pc", io.out_pc_o, fq[0].pc);
      chk("out_instr", io.out_instr_o, fq[0].instr);
      chk("out_exc", io.out_exc_o, fq[0].exc);
    end
    chk("poison", io.poison_o, io.flush_i | miss);
    chk("replay_v", io.replay_v_o, rv);
    if (rv) chk("replay_pc", io.replay_pc_o, rpc);
    @(posedge clk_i);
    if (io.flush_i) begin
      fq.delete();
      pend.delete();
      rv = 1'b0;
    end else begin
      if (io.out_yumi_i) void'(fq.pop_front());
      rv = 1'b0;
      if (resp) begin
        f = pend.pop_front();
        if (miss) begin
          rv  = 1'b1;
          rpc = f.pc;
          pend.delete();
        end else begin
          e.pc    = f.pc;
          e.instr = (acc || pf) ? '0 : data;
          e.exc   = acc ? 2'b10 : pf ? 2'b01 : 2'b00;
          fq.push_back(e);
        end
      end
      if (io.fetch_v_i) begin
        f.pc  = io.fetch_pc_i;
        f.due = cyc + 2;
        pend.push_back(f);
      end
    end
    cyc++;
    #1;
  endtask
  initial begin
    cyc = 0;
    rv  = 1'b0;
    rpc = '0;
    drive_idle();
    #1;
    chk_reset_state();
    @(posedge clk_i);
    @(posedge clk_i);
    #3 reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    repeat (40) step(100, 100, 0, 0, 0);
    repeat (150) step(80, 70, 0, 30, 0);
    repeat (150) step(80, 70, 0, 20, 30);
    repeat (20) step(100, 0, 0, 0, 0);
    step(100, 100, 0, 0, 0);
    repeat (8) step(100, 0, 0, 0, 0);
    repeat (20) step(0, 100, 0, 0, 0);
    repeat (300) step(90, 60, 10, 15, 15);
    repeat (300) step(85, 50, 3, 10, 10);
    repeat (15) step(100, 0, 0, 0, 0);
    #2 reset_n_i = 1'b0;
    drive_idle();
    #1;
    chk_reset_state();
    fq.delete();
    pend.delete();
    rv = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #3 reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;
    repeat (200) step(80, 60, 5, 15, 15);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
